vga_trace_plotter: RTL and testbench
====================================

VGA_TRACE_PLOTTER -- requirements
Module: vga_trace_plotter

Interface
REQ-001 Parameter NUM_CH, default 2: number of stacked trace channels, range 1..4.
REQ-002 Parameter SAMPLES, default 320: samples per channel and box width in pixels.
REQ-003 Parameter BOX_X0, default 55: leftmost box column.
REQ-004 Parameter BOX_Y0 / BOX_H, default {45,254} / {181,180}: per-channel top row and height; boxes do not overlap vertically.
REQ-005 Parameter CH_BASE, default {12'h559,12'h6AD}: per-channel sample base address.
REQ-006 Parameter CH_COLOR, default {12'h0F0,12'hF00}: per-channel 12-bit trace colour.
REQ-007 Parameter SAMPLE_LSB, default 4: LSB of the 8-bit sample field in sig_data.
REQ-008 Parameter SCALE, default 0: right-shift applied to the 8-bit sample.
REQ-009 Parameter MEM_LAT, default 1: sig_data latency in pix_en cycles after sig_addr.
REQ-010 clock  in  1  system clock; all logic on its rising edge.
REQ-011 reset  in  1  synchronous, active-low reset.
REQ-012 pix_en  in  1  pixel strobe; the pipeline advances only when high.
REQ-013 x / y / active / hsync_in / vsync_in  in  10/9/1/1/1  timing-generator outputs for the current pixel.
REQ-014 frame_start  in  1  one-pixel pulse coincident with x=0, y=0.
REQ-015 bg_color  in  12  background pixel colour, aligned with x/y.
REQ-016 head  in  12  circular-buffer write pointer, 0..SAMPLES-1.
REQ-017 plot_mode  in  1  0 = dot, 1 = connected line.
REQ-018 sig_addr  out  12  sample memory read address.
REQ-019 sig_data  in  32  sample memory read data.
REQ-020 rgb_out  out  12  composited colour {R,G,B}.
REQ-021 hsync_out / vsync_out  out  1/1  delayed syncs.

Function
REQ-022 Latency from x/y/bg_color/syncs to rgb_out/syncs SHALL be exactly MEM_LAT+2 pix_en cycles for every signal.
REQ-023 Channel c is hit when BOX_X0 <= x < BOX_X0+SAMPLES and BOX_Y0[c] <= y < BOX_Y0[c]+BOX_H[c]; at most one channel is hit at a time.
REQ-024 On a hit, sig_addr = CH_BASE[c] + ((head_lat + x - BOX_X0) mod SAMPLES), with wrap computed without overflow (add, then subtract SAMPLES if the sum >= SAMPLES).
REQ-025 With no hit, sig_addr holds its last value.
REQ-026 Sample value v = sig_data[SAMPLE_LSB+7:SAMPLE_LSB] >> SCALE, clamped to BOX_H[c]-1; target row r = BOX_Y0[c]+BOX_H[c]-1-v.
REQ-027 Dot mode: the pixel is lit when y == r.
REQ-028 Connect mode: the pixel is lit when min(r_prev,r) <= y <= max(r_prev,r); r_prev is the row of the previous column in the same line, and r_prev = r at x = BOX_X0.
REQ-029 Lit pixel -> CH_COLOR[c]; unlit hit or no hit -> bg_color; active low -> 12'h000.
REQ-030 head and plot_mode are latched into head_lat/mode_lat only on a frame_start pixel; mid-frame changes are ignored until the next frame.
REQ-031 With pix_en low, all pipeline registers and outputs SHALL hold.
REQ-032 head >= SAMPLES is treated as 0 when latched.

Reset
REQ-033 While reset is low at a clock edge: rgb_out=0, hsync_out=vsync_out=1 (inactive), sig_addr=0, head_lat=0, mode_lat=0, and all pipeline valid/active bits cleared.
REQ-034 A reset asserted mid-frame blanks output from the next edge; normal output resumes MEM_LAT+2 pix_en cycles after release.

Structure
REQ-035 A shared package holds the 12-bit colour type, the default geometry, base and colour constants, and the MEM_LAT default.
REQ-036 A sub-module vga_trace_lane (per-pixel channel decode and row compare) SHALL be instantiated once, muxed by channel.

Verification
REQ-037 Head wrap: head=300, pixel x=80 on channel 0 -> sig_addr = 12'h559+5.
REQ-038 Dot mode: sig_data[11:4]=8'd10, channel 0 -> only row 215 is lit in green; rows 214 and 216 show bg_color.
REQ-039 Connect mode: column samples 10 then 40 on channel 1 -> second column lit for rows 393..423 in 12'hF00.
REQ-040 Clamp: sample 255 in a 181-row box -> lit row 45 only.
REQ-041 Mid-frame: head changed at y=100 -> addresses unchanged until frame_start; the new value is used at the next frame.
REQ-042 Latency/reset: MEM_LAT=1, pix_en every 4th clock -> rgb_out aligned 3 strobes after input; reset low mid-line -> rgb_out=0 on the next edge.

Source files
------------

// File: rtl/vga_trace_plotter_pkg.sv
// Shared types and default geometry for the stacked-trace VGA plotter.
package vga_trace_plotter_pkg;

  typedef logic [11:0] color_t;

  localparam int unsigned DefNumCh     = 2;
  localparam int unsigned DefSamples   = 320;
  localparam int unsigned DefBoxX0     = 55;
  localparam int unsigned DefBoxY0 [2] = '{45, 254};
  localparam int unsigned DefBoxH  [2] = '{181, 180};
  localparam logic [11:0] DefChBase [2] = '{12'h559, 12'h6AD};
  localparam color_t      DefChColor [2] = '{12'h0F0, 12'hF00};
  localparam int unsigned DefSampleLsb = 4;
  localparam int unsigned DefScale     = 0;
  localparam int unsigned DefMemLat    = 1;

  // Per-pixel attributes carried alongside the memory read.
  typedef struct packed {
    logic       active;
    logic       hsync;
    logic       vsync;
    logic       hit;
    logic [1:0] ch;
    logic       first;
    logic       mode;
    logic [8:0] y;
    color_t     bg;
  } pix_meta_t;

  localparam pix_meta_t MetaReset = '{
    active: 1'b0, hsync: 1'b1, vsync: 1'b1, hit: 1'b0, ch: 2'd0,
    first: 1'b0, mode: 1'b0, y: 9'd0, bg: 12'h000
  };

endpackage

// File: rtl/vga_trace_plotter_lane.sv
// Channel decode for the incoming pixel and row compare for the pixel whose sample has arrived.
module vga_trace_lane
  import vga_trace_plotter_pkg::*;
#(
  parameter int unsigned NUM_CH          = DefNumCh,
  parameter int unsigned SAMPLES         = DefSamples,
  parameter int unsigned BOX_X0          = DefBoxX0,
  parameter int unsigned BOX_Y0 [NUM_CH] = DefBoxY0,
  parameter int unsigned BOX_H  [NUM_CH] = DefBoxH,
  parameter int unsigned SAMPLE_LSB      = DefSampleLsb,
  parameter int unsigned SCALE           = DefScale
) (
  input  logic [9:0]  dec_x,
  input  logic [8:0]  dec_y,
  output logic        dec_hit,
  output logic [1:0]  dec_ch,
  output logic [9:0]  dec_col,
  input  logic [8:0]  cmp_y,
  input  logic [9:0]  cmp_y0,
  input  logic [9:0]  cmp_h,
  input  logic [31:0] cmp_data,
  input  logic        cmp_first,
  input  logic        cmp_mode,
  input  logic [9:0]  cmp_prev_row,
  output logic [9:0]  cmp_row,
  output logic        cmp_lit
);

  localparam logic [9:0]  X0   = 10'(BOX_X0);
  localparam logic [10:0] XEnd = 11'(BOX_X0 + SAMPLES);

  logic       in_x;
  logic [7:0] raw;
  logic [7:0] scaled;
  logic [9:0] hm1;
  logic [9:0] v;
  logic [9:0] prev;
  logic [9:0] lo;
  logic [9:0] hi;
  logic [9:0] ycmp;

  always_comb begin
    in_x    = (dec_x >= X0) && ({1'b0, dec_x} < XEnd);
    dec_hit = 1'b0;
    dec_ch  = 2'd0;
    dec_col = dec_x - X0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (in_x && ({1'b0, dec_y} >= 10'(BOX_Y0[c])) &&
          ({1'b0, dec_y} < 10'(BOX_Y0[c] + BOX_H[c]))) begin
        dec_hit = 1'b1;
        dec_ch  = 2'(c);
      end
    end
  end

  always_comb begin
    raw     = cmp_data[SAMPLE_LSB +: 8];
    scaled  = raw >> SCALE;
    hm1     = cmp_h - 10'd1;
    v       = ({2'b00, scaled} > hm1) ? hm1 : {2'b00, scaled};
    cmp_row = cmp_y0 + hm1 - v;
    // The leftmost column has no predecessor, so it draws as a dot.
    prev    = cmp_first ? cmp_row : cmp_prev_row;
    lo      = (prev < cmp_row) ? prev : cmp_row;
    hi      = (prev < cmp_row) ? cmp_row : prev;
    ycmp    = {1'b0, cmp_y};
    cmp_lit = cmp_mode ? ((ycmp >= lo) && (ycmp <= hi)) : (ycmp == cmp_row);
  end

endmodule

// File: rtl/vga_trace_plotter.sv
// Overlays NUM_CH sample traces onto a VGA pixel stream, reading samples from an external memory.
module vga_trace_plotter
  import vga_trace_plotter_pkg::*;
#(
  parameter int unsigned NUM_CH            = DefNumCh,
  parameter int unsigned SAMPLES           = DefSamples,
  parameter int unsigned BOX_X0            = DefBoxX0,
  parameter int unsigned BOX_Y0   [NUM_CH] = DefBoxY0,
  parameter int unsigned BOX_H    [NUM_CH] = DefBoxH,
  parameter logic [11:0] CH_BASE  [NUM_CH] = DefChBase,
  parameter color_t      CH_COLOR [NUM_CH] = DefChColor,
  parameter int unsigned SAMPLE_LSB        = DefSampleLsb,
  parameter int unsigned SCALE             = DefScale,
  parameter int unsigned MEM_LAT           = DefMemLat
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pix_en,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  input  logic        active,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        frame_start,
  input  color_t      bg_color,
  input  logic [11:0] head,
  input  logic        plot_mode,
  output logic [11:0] sig_addr,
  input  logic [31:0] sig_data,
  output color_t      rgb_out,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam int unsigned Depth    = MEM_LAT + 1;
  localparam logic [12:0] SamplesW = 13'(SAMPLES);

  logic [11:0] head_lat;
  logic        mode_lat;
  logic [11:0] head_ok;
  logic [11:0] head_eff;
  logic        mode_eff;
  logic [9:0]  r_prev;

  logic        dec_hit;
  logic [1:0]  dec_ch;
  logic [9:0]  dec_col;
  logic [12:0] sum;
  logic [11:0] wrapped;
  logic [11:0] base_sel;
  logic [11:0] addr_next;

  pix_meta_t   meta_in;
  pix_meta_t   meta_q [Depth];
  pix_meta_t   meta_d;

  logic [9:0]  y0_sel;
  logic [9:0]  h_sel;
  color_t      color_sel;
  logic [9:0]  cmp_row;
  logic        cmp_lit;
  color_t      pix_rgb;

  assign meta_d = meta_q[Depth-1];

  vga_trace_lane #(
    .NUM_CH     (NUM_CH),
    .SAMPLES    (SAMPLES),
    .BOX_X0     (BOX_X0),
    .BOX_Y0     (BOX_Y0),
    .BOX_H      (BOX_H),
    .SAMPLE_LSB (SAMPLE_LSB),
    .SCALE      (SCALE)
  ) u_lane (
    .dec_x        (x),
    .dec_y        (y),
    .dec_hit      (dec_hit),
    .dec_ch       (dec_ch),
    .dec_col      (dec_col),
    .cmp_y        (meta_d.y),
    .cmp_y0       (y0_sel),
    .cmp_h        (h_sel),
    .cmp_data     (sig_data),
    .cmp_first    (meta_d.first),
    .cmp_mode     (meta_d.mode),
    .cmp_prev_row (r_prev),
    .cmp_row      (cmp_row),
    .cmp_lit      (cmp_lit)
  );

  // The frame_start pixel already sees the freshly latched head and mode.
  always_comb begin
    head_ok  = (head < 12'(SAMPLES)) ? head : 12'd0;
    head_eff = frame_start ? head_ok : head_lat;
    mode_eff = frame_start ? plot_mode : mode_lat;

    base_sel = 12'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (dec_ch == 2'(c)) base_sel = CH_BASE[c];
    end
    sum       = {1'b0, head_eff} + {3'b000, dec_col};
    wrapped   = (sum >= SamplesW) ? 12'(sum - SamplesW) : sum[11:0];
    addr_next = base_sel + wrapped;

    meta_in = '{
      active: active, hsync: hsync_in, vsync: vsync_in, hit: dec_hit, ch: dec_ch,
      first: (x == 10'(BOX_X0)), mode: mode_eff, y: y, bg: bg_color
    };
  end

  always_comb begin
    y0_sel    = 10'd0;
    h_sel     = 10'd1;
    color_sel = 12'h000;
    for (int c = 0; c < NUM_CH; c++) begin
      if (meta_d.ch == 2'(c)) begin
        y0_sel    = 10'(BOX_Y0[c]);
        h_sel     = 10'(BOX_H[c]);
        color_sel = CH_COLOR[c];
      end
    end
    if (!meta_d.active)                pix_rgb = 12'h000;
    else if (meta_d.hit && cmp_lit)    pix_rgb = color_sel;
    else                               pix_rgb = meta_d.bg;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head_lat  <= 12'd0;
      mode_lat  <= 1'b0;
      sig_addr  <= 12'd0;
      r_prev    <= 10'd0;
      rgb_out   <= 12'h000;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      for (int i = 0; i < Depth; i++) meta_q[i] <= MetaReset;
    end else if (pix_en) begin
      if (frame_start) begin
        head_lat <= head_ok;
        mode_lat <= plot_mode;
      end
      if (dec_hit) sig_addr <= addr_next;
      meta_q[0] <= meta_in;
      for (int i = 1; i < Depth; i++) meta_q[i] <= meta_q[i-1];
      if (meta_d.hit) r_prev <= cmp_row;
      rgb_out   <= pix_rgb;
      hsync_out <= meta_d.hsync;
      vsync_out <= meta_d.vsync;
    end
  end

endmodule

// File: tb/tb_vga_trace_plotter.sv
// Directed bench: pixel strobe every 4th clock, registered sample memory with one strobe of latency.
module tb_vga_trace_plotter;

  logic        clock = 1'b0;
  logic        reset;
  logic        pix_en;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        active;
  logic        hsync_in;
  logic        vsync_in;
  logic        frame_start;
  logic [11:0] bg_color;
  logic [11:0] head;
  logic        plot_mode;
  logic [11:0] sig_addr;
  logic [31:0] sig_data;
  logic [11:0] rgb_out;
  logic        hsync_out;
  logic        vsync_out;

  logic [31:0] mem [4096];
  int          n_total = 0;
  int          n_bad   = 0;
  logic [13:0] exp_q [$];
  string       tag_q [$];

  always #5 clock = ~clock;

  vga_trace_plotter dut (
    .clock       (clock),
    .reset       (reset),
    .pix_en      (pix_en),
    .x           (x),
    .y           (y),
    .active      (active),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .frame_start (frame_start),
    .bg_color    (bg_color),
    .head        (head),
    .plot_mode   (plot_mode),
    .sig_addr    (sig_addr),
    .sig_data    (sig_data),
    .rgb_out     (rgb_out),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out)
  );

  always @(posedge clock) if (pix_en) sig_data <= mem[sig_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One pixel strobe; lit_color of 0 means the pixel is expected to show background.
  task automatic step(input logic [9:0] px, input logic [8:0] py, input logic act,
                      input logic fs, input logic [11:0] lit_color, input logic chk_addr,
                      input logic [11:0] exp_addr, input string tag);
    logic [13:0] e;
    logic [11:0] bg;
    logic [11:0] want;
    string       t;
    logic        popped;
    bg   = {3'b001, py};
    want = !act ? 12'h000 : ((lit_color != 12'h000) ? lit_color : bg);
    @(negedge clock);
    x = px; y = py; active = act; frame_start = fs;
    hsync_in = px[0]; vsync_in = py[0]; bg_color = bg; pix_en = 1'b1;
    exp_q.push_back({want, px[0], py[0]});
    tag_q.push_back(tag);
    @(posedge clock); #1;
    pix_en = 1'b0; frame_start = 1'b0;
    if (chk_addr) check_eq({tag, " addr"}, 32'(sig_addr), 32'(exp_addr));
    popped = 1'b0;
    e = '0;
    t = "";
    if (exp_q.size() >= 3) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      popped = 1'b1;
      check_eq({t, " rgb"}, 32'(rgb_out), 32'(e[13:2]));
      check_eq({t, " hsync"}, 32'(hsync_out), 32'(e[1]));
      check_eq({t, " vsync"}, 32'(vsync_out), 32'(e[0]));
    end
    repeat (3) @(posedge clock);
    #1;
    if (popped) check_eq({t, " rgb hold"}, 32'(rgb_out), 32'(e[13:2]));
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[12'h55E] = 32'hFFFF_F0AF;   // sample 10 with surrounding bits set
    mem[12'h55F] = 32'h0000_0FF0;   // sample 255
    mem[12'h6AF] = 32'h0000_00A0;   // sample 10
    mem[12'h6B0] = 32'h0000_0280;   // sample 40
    reset = 1'b0; pix_en = 1'b0; x = '0; y = '0; active = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; frame_start = 1'b0; bg_color = '0;
    head = 12'd300; plot_mode = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    check_eq("reset rgb", 32'(rgb_out), 32'h0);
    check_eq("reset hsync", 32'(hsync_out), 32'h1);
    check_eq("reset vsync", 32'(vsync_out), 32'h1);
    check_eq("reset addr", 32'(sig_addr), 32'h0);

    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({12'h000, 1'b1, 1'b1});
      tag_q.push_back("post-reset fill");
    end

    // Frame 1: head 300, dot mode.
    step(10'd0,  9'd0,   1'b1, 1'b1, 12'h000, 1'b1, 12'h000, "fs1");
    step(10'd80, 9'd214, 1'b1, 1'b0, 12'h000, 1'b1, 12'h55E, "wrap y214");
    step(10'd80, 9'd215, 1'b1, 1'b0, 12'h0F0, 1'b1, 12'h55E, "dot y215");
    step(10'd80, 9'd216, 1'b1, 1'b0, 12'h000, 1'b1, 12'h55E, "dot y216");
    step(10'd81, 9'd45,  1'b1, 1'b0, 12'h0F0, 1'b1, 12'h55F, "clamp y45");
    step(10'd81, 9'd46,  1'b1, 1'b0, 12'h000, 1'b1, 12'h55F, "clamp y46");
    step(10'd10, 9'd100, 1'b1, 1'b0, 12'h000, 1'b1, 12'h55F, "nohit hold");
    step(10'd81, 9'd45,  1'b0, 1'b0, 12'h000, 1'b1, 12'h55F, "inactive");
    head = 12'd2; plot_mode = 1'b1;
    step(10'd80, 9'd215, 1'b1, 1'b0, 12'h0F0, 1'b1, 12'h55E, "midframe head");
    step(10'd81, 9'd100, 1'b1, 1'b0, 12'h000, 1'b1, 12'h55F, "midframe mode");

    // Frame 2: head 2, connect mode.
    step(10'd0,  9'd0,   1'b1, 1'b1, 12'h000, 1'b0, 12'h000, "fs2");
    step(10'd55, 9'd225, 1'b1, 1'b0, 12'h0F0, 1'b1, 12'h55B, "new head");
    step(10'd55, 9'd393, 1'b1, 1'b0, 12'h000, 1'b1, 12'h6AF, "c0 y393");
    step(10'd56, 9'd393, 1'b1, 1'b0, 12'hF00, 1'b1, 12'h6B0, "c1 y393");
    step(10'd55, 9'd410, 1'b1, 1'b0, 12'h000, 1'b1, 12'h6AF, "c0 y410");
    step(10'd56, 9'd410, 1'b1, 1'b0, 12'hF00, 1'b1, 12'h6B0, "c1 y410");
    step(10'd55, 9'd423, 1'b1, 1'b0, 12'hF00, 1'b1, 12'h6AF, "c0 y423");
    step(10'd56, 9'd423, 1'b1, 1'b0, 12'hF00, 1'b1, 12'h6B0, "c1 y423");
    step(10'd55, 9'd392, 1'b1, 1'b0, 12'h000, 1'b1, 12'h6AF, "c0 y392");
    step(10'd56, 9'd392, 1'b1, 1'b0, 12'h000, 1'b1, 12'h6B0, "c1 y392");
    step(10'd55, 9'd424, 1'b1, 1'b0, 12'h000, 1'b1, 12'h6AF, "c0 y424");
    step(10'd56, 9'd424, 1'b1, 1'b0, 12'h000, 1'b1, 12'h6B0, "c1 y424");

    // Reset in the middle of a line.
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    check_eq("midreset rgb", 32'(rgb_out), 32'h0);
    check_eq("midreset hsync", 32'(hsync_out), 32'h1);
    check_eq("midreset vsync", 32'(vsync_out), 32'h1);
    check_eq("midreset addr", 32'(sig_addr), 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    exp_q.delete();
    tag_q.delete();
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({12'h000, 1'b1, 1'b1});
      tag_q.push_back("post-midreset fill");
    end

    // head_lat and mode_lat are back to 0 without a frame_start.
    step(10'd80, 9'd225, 1'b1, 1'b0, 12'h0F0, 1'b1, 12'h572, "after reset");
    step(10'd5,  9'd5,   1'b0, 1'b0, 12'h000, 1'b0, 12'h000, "flush a");
    step(10'd5,  9'd5,   1'b0, 1'b0, 12'h000, 1'b0, 12'h000, "flush b");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
